noc_traffic_node: RTL and testbench

- Parametrised NoC endpoint traffic generator and checker. Attaches to one router local port in place of a simple fixed test node.
- TX side sends a programmable number of packets. Each packet has a header flit, N payload flits and a tail flit, with a programmable inter-packet gap and full valid/ready hold semantics.
- RX side checks every arriving packet for format, destination and payload pattern, and keeps good-packet and error counters for testbench scoreboarding.

---
 rtl/noc_traffic_node.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_noc_traffic_node.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_node.sv
`default_nettype none
// ============================================================================
// Module   : noc_traffic_node
// Purpose  : NoC endpoint traffic generator (TX) and packet checker (RX).
//            TX emits cfg_pkt_num packets of header + N payload + tail flits
//            with a programmable gap. RX validates format, destination and
//            payload pattern, and counts good and bad packets.
// Ports    : noc_clk/noc_rst_n   clock, async active-low reset
//            i_start, i_cfg_*    run launch and per-run configuration
//            i_rx_stall          RX backpressure request
//            i_receive_*/o_receive_ready   inbound flit channel
//            o_sender_*/i_sender_ready     outbound flit channel
//            o_tx_busy/o_tx_done/o_tx_pkt_cnt   TX run status
//            o_rx_pkt_cnt/o_rx_err_cnt/o_rx_err_flag  RX statistics
// Revision : 1.0 - initial release
// ============================================================================
module noc_traffic_node #(
  parameter int DATA_W = 128,
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int X_ID   = 0,
  parameter int Y_ID   = 0
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              i_start,
  input  logic [X_W-1:0]    i_cfg_dest_x,
  input  logic [Y_W-1:0]    i_cfg_dest_y,
  input  logic [15:0]       i_cfg_pkt_num,
  input  logic [7:0]        i_cfg_payload_len,
  input  logic [7:0]        i_cfg_gap,
  input  logic              i_rx_stall,
  input  logic              i_receive_valid,
  output logic              o_receive_ready,
  input  logic [DATA_W-1:0] i_receive_flit,
  input  logic              i_receive_is_header,
  input  logic              i_receive_is_tail,
  output logic              o_sender_valid,
  input  logic              i_sender_ready,
  output logic [DATA_W-1:0] o_sender_flit,
  output logic              o_sender_is_header,
  output logic              o_sender_is_tail,
  output logic              o_tx_busy,
  output logic              o_tx_done,
  output logic [15:0]       o_tx_pkt_cnt,
  output logic [15:0]       o_rx_pkt_cnt,
  output logic [15:0]       o_rx_err_cnt,
  output logic              o_rx_err_flag
);

  localparam int c_CW = X_W + Y_W;
  localparam int c_HW = 24 + 2 * c_CW;
  localparam logic [c_CW-1:0] c_SELF = {X_W'(X_ID), Y_W'(Y_ID)};

  // Header/tail: zeros above {src, dst, len, seq}
  function automatic logic [DATA_W-1:0] f_hdr(input logic [c_CW-1:0] src,
                                              input logic [c_CW-1:0] dst,
                                              input logic [7:0] len,
                                              input logic [15:0] seq);
    logic [DATA_W-1:0] v;
    v = '0;
    v[c_HW-1:0] = {src, dst, len, seq};
    return v;
  endfunction

  // Payload: ones above {index, seq}
  function automatic logic [DATA_W-1:0] f_pay(input logic [7:0] idx,
                                              input logic [15:0] seq);
    logic [DATA_W-1:0] v;
    v = '1;
    v[23:0] = {idx, seq};
    return v;
  endfunction

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_DATA, TX_TAIL, TX_GAP} tx_state_t;

  tx_state_t         r_tx_state;
  logic [c_CW-1:0]   r_dst;
  logic [15:0]       r_pkt_num;
  logic [7:0]        r_len;
  logic [7:0]        r_gap;
  logic [7:0]        r_gap_cnt;
  logic [7:0]        r_idx;
  logic [15:0]       r_seq;
  logic [15:0]       r_tx_pkt_cnt;
  logic              r_sender_valid;
  logic [DATA_W-1:0] r_sender_flit;
  logic              r_sender_is_header;
  logic              r_sender_is_tail;
  logic              r_tx_busy;
  logic              r_tx_done;

  logic [15:0]       w_seq_inc;
  logic [15:0]       w_tx_cnt_inc;
  logic              w_tx_last;

  assign w_seq_inc    = r_seq + 16'd1;
  assign w_tx_cnt_inc = (r_tx_pkt_cnt == 16'hFFFF) ? r_tx_pkt_cnt : r_tx_pkt_cnt + 16'd1;
  // 17-bit compare so a saturated count still terminates a 0xFFFF run
  assign w_tx_last    = (({1'b0, r_tx_pkt_cnt} + 17'd1) == {1'b0, r_pkt_num});

  // In HEAD/DATA/TAIL sender_valid is always 1, so ready alone means transfer
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_tx_state         <= TX_IDLE;
      r_dst              <= '0;
      r_pkt_num          <= '0;
      r_len              <= '0;
      r_gap              <= '0;
      r_gap_cnt          <= '0;
      r_idx              <= '0;
      r_seq              <= '0;
      r_tx_pkt_cnt       <= '0;
      r_sender_valid     <= 1'b0;
      r_sender_flit      <= '0;
      r_sender_is_header <= 1'b0;
      r_sender_is_tail   <= 1'b0;
      r_tx_busy          <= 1'b0;
      r_tx_done          <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (i_start) begin
            r_dst        <= {i_cfg_dest_x, i_cfg_dest_y};
            r_pkt_num    <= i_cfg_pkt_num;
            r_len        <= i_cfg_payload_len;
            r_gap        <= i_cfg_gap;
            r_tx_pkt_cnt <= '0;
            if (i_cfg_pkt_num == 16'd0) begin
              r_tx_done <= 1'b1;
            end else begin
              r_tx_state         <= TX_HEAD;
              r_sender_valid     <= 1'b1;
              r_sender_flit      <= f_hdr(c_SELF, {i_cfg_dest_x, i_cfg_dest_y},
                                          i_cfg_payload_len, r_seq);
              r_sender_is_header <= 1'b1;
              r_sender_is_tail   <= 1'b0;
              r_tx_busy          <= 1'b1;
            end
          end
        end
        TX_HEAD: begin
          if (i_sender_ready) begin
            r_sender_is_header <= 1'b0;
            r_idx              <= '0;
            if (r_len != 8'd0) begin
              r_tx_state    <= TX_DATA;
              r_sender_flit <= f_pay(8'd0, r_seq);
            end else begin
              r_tx_state       <= TX_TAIL;
              r_sender_flit    <= f_hdr(c_SELF, r_dst, r_len, r_seq);
              r_sender_is_tail <= 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (i_sender_ready) begin
            if (r_idx == r_len - 8'd1) begin
              r_tx_state       <= TX_TAIL;
              r_sender_flit    <= f_hdr(c_SELF, r_dst, r_len, r_seq);
              r_sender_is_tail <= 1'b1;
            end else begin
              r_idx         <= r_idx + 8'd1;
              r_sender_flit <= f_pay(r_idx + 8'd1, r_seq);
            end
          end
        end
        TX_TAIL: begin
          if (i_sender_ready) begin
            r_tx_pkt_cnt     <= w_tx_cnt_inc;
            r_seq            <= w_seq_inc;
            r_sender_is_tail <= 1'b0;
            if (w_tx_last) begin
              r_tx_state     <= TX_IDLE;
              r_sender_valid <= 1'b0;
              r_tx_busy      <= 1'b0;
              r_tx_done      <= 1'b1;
            end else if (r_gap == 8'd0) begin
              // back-to-back header, no bubble
              r_tx_state         <= TX_HEAD;
              r_sender_flit      <= f_hdr(c_SELF, r_dst, r_len, w_seq_inc);
              r_sender_is_header <= 1'b1;
            end else begin
              r_tx_state     <= TX_GAP;
              r_sender_valid <= 1'b0;
              r_gap_cnt      <= r_gap;
            end
          end
        end
        TX_GAP: begin
          if (r_gap_cnt == 8'd1) begin
            r_tx_state         <= TX_HEAD;
            r_sender_valid     <= 1'b1;
            r_sender_flit      <= f_hdr(c_SELF, r_dst, r_len, r_seq);
            r_sender_is_header <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {RX_HEAD, RX_DATA, RX_TAIL} rx_state_t;

  rx_state_t         r_rx_state;
  logic              r_receive_ready;
  logic [DATA_W-1:0] r_rx_hdr;
  logic [7:0]        r_rx_len;
  logic [15:0]       r_rx_seq;
  logic [7:0]        r_rx_idx;
  logic              r_rx_pe;
  logic [15:0]       r_rx_pkt_cnt;
  logic [15:0]       r_rx_err_cnt;
  logic              r_rx_err_flag;

  logic              w_rx_fire;
  logic              w_rx_capture;
  logic              w_rx_ok;
  logic              w_rx_err;
  logic [c_CW-1:0]   w_f_dst;
  logic [7:0]        w_f_len;
  logic [DATA_W-1:0] w_exp_pay;

  assign w_rx_fire    = i_receive_valid && r_receive_ready;
  assign w_f_dst      = i_receive_flit[24 + c_CW - 1 : 24];
  assign w_f_len      = i_receive_flit[23:16];
  assign w_exp_pay    = f_pay(r_rx_idx, r_rx_seq);
  // A header restarts packet tracking both when idle and mid-payload
  assign w_rx_capture = w_rx_fire && i_receive_is_header &&
                        (r_rx_state == RX_HEAD || r_rx_state == RX_DATA);

  always_comb begin
    w_rx_ok  = 1'b0;
    w_rx_err = 1'b0;
    if (w_rx_fire) begin
      case (r_rx_state)
        RX_HEAD: w_rx_err = !i_receive_is_header;
        RX_DATA: w_rx_err = i_receive_is_header || i_receive_is_tail;
        RX_TAIL: begin
          w_rx_ok  = i_receive_is_tail && (i_receive_flit == r_rx_hdr) && !r_rx_pe;
          w_rx_err = !w_rx_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_rx_state      <= RX_HEAD;
      r_receive_ready <= 1'b1;
      r_rx_hdr        <= '0;
      r_rx_len        <= '0;
      r_rx_seq        <= '0;
      r_rx_idx        <= '0;
      r_rx_pe         <= 1'b0;
      r_rx_pkt_cnt    <= '0;
      r_rx_err_cnt    <= '0;
      r_rx_err_flag   <= 1'b0;
    end else begin
      r_receive_ready <= !i_rx_stall;
      if (w_rx_ok && r_rx_pkt_cnt != 16'hFFFF) r_rx_pkt_cnt <= r_rx_pkt_cnt + 16'd1;
      if (w_rx_err) begin
        r_rx_err_flag <= 1'b1;
        if (r_rx_err_cnt != 16'hFFFF) r_rx_err_cnt <= r_rx_err_cnt + 16'd1;
      end
      if (w_rx_capture) begin
        r_rx_hdr   <= i_receive_flit;
        r_rx_len   <= w_f_len;
        r_rx_seq   <= i_receive_flit[15:0];
        r_rx_idx   <= '0;
        r_rx_pe    <= (w_f_dst != c_SELF);
        r_rx_state <= (w_f_len != 8'd0) ? RX_DATA : RX_TAIL;
      end else if (w_rx_fire) begin
        case (r_rx_state)
          RX_DATA: begin
            if (i_receive_is_tail) begin
              r_rx_state <= RX_HEAD;
            end else begin
              if (i_receive_flit != w_exp_pay) r_rx_pe <= 1'b1;
              if (r_rx_idx == r_rx_len - 8'd1) r_rx_state <= RX_TAIL;
              else r_rx_idx <= r_rx_idx + 8'd1;
            end
          end
          RX_TAIL: r_rx_state <= RX_HEAD;
          default: r_rx_state <= RX_HEAD;
        endcase
      end
    end
  end

  assign o_receive_ready    = r_receive_ready;
  assign o_sender_valid     = r_sender_valid;
  assign o_sender_flit      = r_sender_flit;
  assign o_sender_is_header = r_sender_is_header;
  assign o_sender_is_tail   = r_sender_is_tail;
  assign o_tx_busy          = r_tx_busy;
  assign o_tx_done          = r_tx_done;
  assign o_tx_pkt_cnt       = r_tx_pkt_cnt;
  assign o_rx_pkt_cnt       = r_rx_pkt_cnt;
  assign o_rx_err_cnt       = r_rx_err_cnt;
  assign o_rx_err_flag      = r_rx_err_flag;

endmodule
`default_nettype wire

// File: tb/tb_noc_traffic_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_traffic_node
// Purpose  : Self-checking bench for noc_traffic_node. Table of TX runs with
//            an expected-flit scoreboard, optional loopback into the RX side,
//            plus hand-written reset and RX error-injection sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_traffic_node;

  typedef logic [129:0] exp_t;  // {is_header, is_tail, flit}

  typedef struct {
    bit do_rst;
    int pkt_num;
    int len;
    int gap;
    bit rand_rdy;
    bit loop;
    bit rand_stall;
    bit bad_start;
    int exp_vcyc;     // expected valid cycles, -1 = not checked
    int exp_tx_cnt;
  } run_t;

  logic         noc_clk = 1'b0;
  logic         noc_rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   cfg_dx = '0, cfg_dy = '0;
  logic [15:0]  cfg_pkt = '0;
  logic [7:0]   cfg_len = '0, cfg_gap = '0;
  logic         rx_stall = 1'b0;
  logic         tb_rvalid = 1'b0, tb_rh = 1'b0, tb_rt = 1'b0, tb_sready = 1'b1;
  logic [127:0] tb_rflit = '0;
  logic         loop = 1'b0, rand_rdy = 1'b0, rand_stall = 1'b0, stall_force = 1'b0;

  wire          w_sready, w_rvalid, w_rh, w_rt;
  wire  [127:0] w_rflit;
  logic         o_receive_ready, o_sender_valid, o_sender_is_header, o_sender_is_tail;
  logic [127:0] o_sender_flit;
  logic         o_tx_busy, o_tx_done, o_rx_err_flag;
  logic [15:0]  o_tx_pkt_cnt, o_rx_pkt_cnt, o_rx_err_cnt;

  assign w_sready = loop ? o_receive_ready    : tb_sready;
  assign w_rvalid = loop ? o_sender_valid     : tb_rvalid;
  assign w_rflit  = loop ? o_sender_flit      : tb_rflit;
  assign w_rh     = loop ? o_sender_is_header : tb_rh;
  assign w_rt     = loop ? o_sender_is_tail   : tb_rt;

  noc_traffic_node #(.DATA_W(128), .X_W(4), .Y_W(4), .X_ID(2), .Y_ID(3)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .i_start(start),
    .i_cfg_dest_x(cfg_dx), .i_cfg_dest_y(cfg_dy), .i_cfg_pkt_num(cfg_pkt),
    .i_cfg_payload_len(cfg_len), .i_cfg_gap(cfg_gap), .i_rx_stall(rx_stall),
    .i_receive_valid(w_rvalid), .o_receive_ready(o_receive_ready),
    .i_receive_flit(w_rflit), .i_receive_is_header(w_rh), .i_receive_is_tail(w_rt),
    .o_sender_valid(o_sender_valid), .i_sender_ready(w_sready),
    .o_sender_flit(o_sender_flit), .o_sender_is_header(o_sender_is_header),
    .o_sender_is_tail(o_sender_is_tail), .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done),
    .o_tx_pkt_cnt(o_tx_pkt_cnt), .o_rx_pkt_cnt(o_rx_pkt_cnt),
    .o_rx_err_cnt(o_rx_err_cnt), .o_rx_err_flag(o_rx_err_flag)
  );

  always #5 noc_clk = ~noc_clk;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [15:0] seq_m = '0;
  int   vcyc = 0, done_cnt = 0, idle = 0, exp_gap = 0;
  bit   pend = 0, gap_watch = 0, done_due = 0;
  exp_t prev, m_e;
  run_t tbl[13];

  function automatic logic [127:0] bhdr(input logic [3:0] sx, input logic [3:0] sy,
                                        input logic [3:0] dx, input logic [3:0] dy,
                                        input logic [7:0] len, input logic [15:0] seq);
    return {88'h0, sx, sy, dx, dy, len, seq};
  endfunction

  function automatic logic [127:0] bpay(input logic [7:0] i, input logic [15:0] seq);
    return {{104{1'b1}}, i, seq};
  endfunction

  task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  // Background randomisation of router ready and RX stall
  initial begin
    forever begin
      @(posedge noc_clk);
      #1;
      tb_sready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_stall  = rand_stall ? ($urandom_range(0, 3) == 0) : stall_force;
    end
  end

  // TX monitor: scoreboard pop, hold stability, gap length and done timing
  always @(negedge noc_clk) begin
    if (!noc_rst_n) begin
      pend = 0; gap_watch = 0; done_due = 0;
      q.delete();
    end else begin
      if (pend) begin
        chk("hold_valid", 130'(o_sender_valid), 130'(1));
        chk("hold_flit", {o_sender_is_header, o_sender_is_tail, o_sender_flit}, prev);
      end
      pend = o_sender_valid && !w_sready;
      prev = {o_sender_is_header, o_sender_is_tail, o_sender_flit};
      if (o_sender_valid) vcyc++;
      if (done_due) begin
        chk("tx_done_timing", 130'(o_tx_done), 130'(1));
        chk("busy_after_done", 130'(o_tx_busy), 130'(0));
        done_due = 0;
      end
      if (o_tx_done) done_cnt++;
      if (gap_watch) begin
        if (o_sender_valid) begin
          chk("gap_len", 130'(idle), 130'(exp_gap));
          gap_watch = 0;
        end else if (o_tx_busy) idle++;
        else gap_watch = 0;
      end
      if (o_sender_valid && w_sready) begin
        if (q.size() == 0) begin
          chk("unexpected_flit", 130'(1), 130'(0));
        end else begin
          m_e = q.pop_front();
          chk("flit", {o_sender_is_header, o_sender_is_tail, o_sender_flit}, m_e);
          if (o_sender_is_tail) begin
            if (q.size() == 0) done_due = 1;
            else begin gap_watch = 1; idle = 0; end
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 130'(o_sender_valid), 130'(0));
    chk({tag, "_flit"}, {o_sender_is_header, o_sender_is_tail, o_sender_flit}, 130'(0));
    chk({tag, "_busy_done"}, 130'({o_tx_busy, o_tx_done}), 130'(0));
    chk({tag, "_counts"}, 130'({o_tx_pkt_cnt, o_rx_pkt_cnt, o_rx_err_cnt}), 130'(0));
    chk({tag, "_errflag"}, 130'(o_rx_err_flag), 130'(0));
    chk({tag, "_rx_ready"}, 130'(o_receive_ready), 130'(1));
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    rand_rdy = 0; rand_stall = 0; stall_force = 0; loop = 0;
    tb_rvalid = 0; start = 0;
    repeat (2) tick();
    check_reset_vals("reset");
    noc_rst_n = 1'b1;
    seq_m = '0;
    q.delete();
    tick();
  endtask

  task automatic push_run(input int pkt_num, input int len);
    logic [127:0] h;
    for (int p = 0; p < pkt_num; p++) begin
      h = bhdr(4'd2, 4'd3, cfg_dx, cfg_dy, 8'(len), seq_m);
      q.push_back({2'b10, h});
      for (int i = 0; i < len; i++) q.push_back({2'b00, bpay(8'(i), seq_m)});
      q.push_back({2'b01, h});
      seq_m = seq_m + 16'd1;
    end
  endtask

  task automatic run(input run_t r);
    int n;
    if (r.do_rst) do_reset();
    loop = r.loop; rand_rdy = r.rand_rdy; rand_stall = r.rand_stall;
    exp_gap = r.gap;
    cfg_dx = r.loop ? 4'd2 : 4'd5;
    cfg_dy = r.loop ? 4'd3 : 4'd9;
    cfg_pkt = 16'(r.pkt_num); cfg_len = 8'(r.len); cfg_gap = 8'(r.gap);
    push_run(r.pkt_num, r.len);
    vcyc = 0; done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (r.bad_start) begin
      repeat (3) tick();
      chk("busy_before_restart", 130'(o_tx_busy), 130'(1));
      cfg_dx = 4'd7; cfg_pkt = 16'd5; cfg_len = 8'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = 0;
    while ((o_tx_busy || q.size() != 0) && n < 20000) begin tick(); n++; end
    chk("run_timeout", 130'(n < 20000), 130'(1));
    repeat (3) tick();
    chk("tx_pkt_cnt", 130'(o_tx_pkt_cnt), 130'(r.exp_tx_cnt));
    chk("tx_done_pulses", 130'(done_cnt), 130'(1));
    chk("flits_left", 130'(q.size()), 130'(0));
    if (r.exp_vcyc >= 0) chk("valid_cycles", 130'(vcyc), 130'(r.exp_vcyc));
  endtask

  task automatic send(input logic [127:0] f, input bit h, input bit t);
    int n;
    tb_rflit = f; tb_rh = h; tb_rt = t; tb_rvalid = 1'b1;
    n = 0;
    @(negedge noc_clk);
    while (!o_receive_ready && n < 100) begin @(negedge noc_clk); n++; end
    chk("rx_accept_timeout", 130'(n < 100), 130'(1));
    tick();
    tb_rvalid = 1'b0;
  endtask

  initial begin
    int lens[8];
    int gaps[8];
    logic [127:0] h, f;
    run_t r1;
    lens = '{1, 2, 17, 64, 128, 200, 254, 255};
    gaps = '{2, 0, 1, 0, 3, 0, 0, 1};
    //            rst pkt len gap rrdy loop stl bad vcyc txcnt
    tbl[0] = '{1'b1, 1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1};
    tbl[1] = '{1'b1, 3, 4, 5, 1'b1, 1'b0, 1'b0, 1'b0, -1, 3};
    tbl[2] = '{1'b0, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3] = '{1'b0, 1, 20, 0, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1};
    tbl[4] = '{1'b1, 2, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 2};
    for (int k = 0; k < 8; k++)
      tbl[5 + k] = '{1'b0, 1, lens[k], gaps[k], 1'b0, 1'b1, 1'b1, 1'b0, -1, 1};

    do_reset();
    for (int i = 0; i < 13; i++) run(tbl[i]);
    chk("loop_rx_pkt_cnt", 130'(o_rx_pkt_cnt), 130'(10));
    chk("loop_rx_err_cnt", 130'(o_rx_err_cnt), 130'(0));
    chk("loop_rx_err_flag", 130'(o_rx_err_flag), 130'(0));

    // Reset asserted while the TX is in the payload phase
    do_reset();
    cfg_dx = 4'd5; cfg_dy = 4'd9; cfg_pkt = 16'd1; cfg_len = 8'd8; cfg_gap = 8'd0;
    push_run(1, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("mid_data_valid", 130'({o_sender_valid, o_sender_is_header}), 130'(2'b10));
    #2 noc_rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    tick();
    noc_rst_n = 1'b1;
    q.delete();
    seq_m = '0;
    tick();
    r1 = '{1'b0, 1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1};
    run(r1);

    // RX error injection (node is at (2,3))
    do_reset();
    h = bhdr(4'd1, 4'd1, 4'd2, 4'd3, 8'd1, 16'd5);
    send(h, 1, 0); send(bpay(8'd0, 16'd5), 0, 0); send(h, 0, 1);
    chk("good_pkt_cnt", 130'(o_rx_pkt_cnt), 130'(1));
    chk("good_err_cnt", 130'(o_rx_err_cnt), 130'(0));
    // truncated packet cut off by a header addressed elsewhere
    h = bhdr(4'd1, 4'd1, 4'd2, 4'd3, 8'd2, 16'd6);
    send(h, 1, 0); send(bpay(8'd0, 16'd6), 0, 0);
    h = bhdr(4'd1, 4'd1, 4'd4, 4'd4, 8'd1, 16'd7);
    send(h, 1, 0);
    chk("abort_err_cnt", 130'(o_rx_err_cnt), 130'(1));
    chk("abort_err_flag", 130'(o_rx_err_flag), 130'(1));
    send(bpay(8'd0, 16'd7), 0, 0); send(h, 0, 1);
    chk("wrong_dst_err_cnt", 130'(o_rx_err_cnt), 130'(2));
    // corrupted payload byte
    h = bhdr(4'd1, 4'd1, 4'd2, 4'd3, 8'd2, 16'd8);
    f = bpay(8'd1, 16'd8);
    f[7:0] = f[7:0] ^ 8'hA5;
    send(h, 1, 0); send(bpay(8'd0, 16'd8), 0, 0); send(f, 0, 0); send(h, 0, 1);
    chk("corrupt_err_cnt", 130'(o_rx_err_cnt), 130'(3));
    // stray payload while idle, first held off by a stall
    stall_force = 1'b1;
    repeat (2) tick();
    chk("stall_ready", 130'(o_receive_ready), 130'(0));
    tb_rflit = bpay(8'd0, 16'd9); tb_rh = 0; tb_rt = 0; tb_rvalid = 1'b1;
    repeat (3) tick();
    chk("stalled_not_consumed", 130'(o_rx_err_cnt), 130'(3));
    stall_force = 1'b0;
    send(bpay(8'd0, 16'd9), 0, 0);
    chk("stray_err_cnt", 130'(o_rx_err_cnt), 130'(4));
    chk("final_rx_pkt_cnt", 130'(o_rx_pkt_cnt), 130'(1));
    chk("final_err_flag", 130'(o_rx_err_flag), 130'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_chk, n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
